// File: rtl/audio_tone_pkg.sv
// audio_tone_pkg
// Shared types and defaults for the multi-channel audio test-tone source.
//   wave_mode_t   : per-channel waveform select (saw/square/triangle/silent)
//   DEF_*         : default widths for the top-level parameters
//   spread_phase  : reset phase of channel ch when phases are spread evenly
package audio_tone_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW      = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SILENT   = 2'd3
    } wave_mode_t;

    localparam int DEF_BIT_WIDTH   = 16;
    localparam int DEF_CHANNELS    = 2;
    localparam int DEF_PHASE_WIDTH = 24;

    // ch * 2^pw / chans, computed wide so that pw up to 32 cannot overflow.
    function automatic logic [63:0] spread_phase(input int ch, input int chans, input int pw);
        return (64'(ch) << pw) / 64'(chans);
    endfunction

endpackage

// File: rtl/delta_sigma_dac.sv
// delta_sigma_dac
// First-order delta-sigma modulator: turns an unsigned sample word into a
// 1-bit stream whose ones density is level / 2^BIT_WIDTH.
//   clk_audio : sample clock
//   reset_n   : asynchronous active-low reset
//   level     : unsigned sample word
//   pwm       : bitstream (carry of the accumulator)
module delta_sigma_dac #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk_audio,
    input  logic                 reset_n,
    input  logic [BIT_WIDTH-1:0] level,
    output logic                 pwm
);

    logic [BIT_WIDTH:0] r_acc;

    // The carry is dropped each cycle and becomes the output bit; the residue
    // keeps the quantisation error for the next sample.
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) r_acc <= '0;
        else          r_acc <= {1'b0, r_acc[BIT_WIDTH-1:0]} + {1'b0, level};
    end

    assign pwm = r_acc[BIT_WIDTH];

endmodule

// File: rtl/audio_tone_gen.sv
// audio_tone_gen
// Multi-channel audio test-tone source. Each channel runs a phase
// accumulator, shapes it into saw/square/triangle/silence, registers the
// sample word and drives a delta-sigma PWM pin.
// Optional build macro AUDIO_TONE_GEN_VOLUME_EN adds a per-channel 4-bit
// right-shift volume control.
//   clk_audio : one sample per rising edge
//   reset_n   : asynchronous active-low reset
//   enable    : 1 = run, 0 = freeze phase and mute
//   mode      : 2 bits per channel, wave_mode_t
//   phase_inc : PHASE_WIDTH bits per channel, phase step per sample
//   volume    : (AUDIO_TONE_GEN_VOLUME_EN only) 4 bits per channel, shift
//   level     : BIT_WIDTH bits per channel, registered sample word
//   pwm       : 1 bit per channel, delta-sigma bitstream
module audio_tone_gen
    import audio_tone_pkg::*;
#(
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
    parameter int PHASE_SPREAD = 0
) (
    input  logic                            clk_audio,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [2*CHANNELS-1:0]           mode,
    input  logic [PHASE_WIDTH*CHANNELS-1:0] phase_inc,
`ifdef AUDIO_TONE_GEN_VOLUME_EN
    input  logic [4*CHANNELS-1:0]           volume,
`endif
    output logic [BIT_WIDTH*CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]             pwm
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [PHASE_WIDTH-1:0] RST_PHASE =
            (PHASE_SPREAD != 0) ? PHASE_WIDTH'(spread_phase(g, CHANNELS, PHASE_WIDTH)) : '0;

        logic [PHASE_WIDTH-1:0] r_phase;
        logic [PHASE_WIDTH-1:0] r_inc;
        wave_mode_t             r_mode;
        logic [BIT_WIDTH-1:0]   r_level;
        logic [PHASE_WIDTH:0]   w_sum;
        logic                   w_load;
        logic [BIT_WIDTH-1:0]   w_tri;
        logic [BIT_WIDTH-1:0]   w_wave;
        logic [BIT_WIDTH-1:0]   w_shaped;

        assign w_sum = {1'b0, r_phase} + {1'b0, r_inc};

        // Shadow registers only change on a period boundary, while muted, or
        // when idle (inc == 0), so a running tone never glitches mid-period.
        assign w_load = (enable && w_sum[PHASE_WIDTH]) || !enable || (r_inc == '0);

        always_ff @(posedge clk_audio or negedge reset_n) begin
            if (!reset_n) begin
                r_phase <= RST_PHASE;
                r_inc   <= '0;
                r_mode  <= WAVE_SILENT;
            end else begin
                if (enable) r_phase <= w_sum[PHASE_WIDTH-1:0];
                if (w_load) begin
                    r_inc  <= phase_inc[g*PHASE_WIDTH +: PHASE_WIDTH];
                    r_mode <= wave_mode_t'(mode[2*g +: 2]);
                end
            end
        end

        // Triangle folds the second half of the period back down.
        assign w_tri = r_phase[PHASE_WIDTH-1] ? ~r_phase[PHASE_WIDTH-2 -: BIT_WIDTH]
                                              :  r_phase[PHASE_WIDTH-2 -: BIT_WIDTH];

        always_comb begin
            w_wave = '0;
            case (r_mode)
                WAVE_SAW:      w_wave = r_phase[PHASE_WIDTH-1 -: BIT_WIDTH];
                WAVE_SQUARE:   w_wave = r_phase[PHASE_WIDTH-1] ? '0 : '1;
                WAVE_TRIANGLE: w_wave = w_tri;
                default:       w_wave = '0;
            endcase
        end

`ifdef AUDIO_TONE_GEN_VOLUME_EN
        logic [3:0] r_vol;

        always_ff @(posedge clk_audio or negedge reset_n) begin
            if (!reset_n)    r_vol <= '0;
            else if (w_load) r_vol <= volume[4*g +: 4];
        end

        // Shift of 15 is treated as full mute rather than leaving the MSB.
        assign w_shaped = (r_vol >= 4'd15) ? '0 : (w_wave >> r_vol);
`else
        assign w_shaped = w_wave;
`endif

        always_ff @(posedge clk_audio or negedge reset_n) begin
            if (!reset_n)    r_level <= '0;
            else if (enable) r_level <= w_shaped;
            else             r_level <= '0;
        end

        assign level[g*BIT_WIDTH +: BIT_WIDTH] = r_level;

        delta_sigma_dac #(
            .BIT_WIDTH (BIT_WIDTH)
        ) u_dac (
            .clk_audio (clk_audio),
            .reset_n   (reset_n),
            .level     (r_level),
            .pwm       (pwm[g])
        );
    end

endmodule

// File: tb/tb_audio_tone_gen.sv
// tb_audio_tone_gen
// Directed bench for audio_tone_gen: two instances share stimulus, one with
// all channels reset to phase 0 and one with spread reset phases.
module tb_audio_tone_gen;

    logic        clk_audio;
    logic        reset_n;
    logic        enable;
    logic [3:0]  mode;
    logic [47:0] phase_inc;
    logic [7:0]  volume;
    logic [31:0] lvl_a;
    logic [31:0] lvl_s;
    logic [1:0]  pwm_a;
    logic [1:0]  pwm_s;

    int n_tests = 0;
    int n_fail  = 0;

    audio_tone_gen #(.BIT_WIDTH(16), .CHANNELS(2), .PHASE_WIDTH(24), .PHASE_SPREAD(0)) u_dut (
        .clk_audio (clk_audio),
        .reset_n   (reset_n),
        .enable    (enable),
        .mode      (mode),
        .phase_inc (phase_inc),
`ifdef AUDIO_TONE_GEN_VOLUME_EN
        .volume    (volume),
`endif
        .level     (lvl_a),
        .pwm       (pwm_a)
    );

    audio_tone_gen #(.BIT_WIDTH(16), .CHANNELS(2), .PHASE_WIDTH(24), .PHASE_SPREAD(1)) u_dut_sp (
        .clk_audio (clk_audio),
        .reset_n   (reset_n),
        .enable    (enable),
        .mode      (mode),
        .phase_inc (phase_inc),
`ifdef AUDIO_TONE_GEN_VOLUME_EN
        .volume    (volume),
`endif
        .level     (lvl_s),
        .pwm       (pwm_s)
    );

    initial clk_audio = 1'b0;
    always #5 clk_audio = ~clk_audio;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_audio);
        #1;
    endtask

    // Reset, release between edges, then consume the shadow-load edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        @(negedge clk_audio);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        logic [15:0] e0;
        logic [15:0] e1;

        reset_n   = 1'b1;
        enable    = 1'b1;
        volume    = '0;
        mode      = {2'd3, 2'd0};
        phase_inc = {24'h000000, 24'h010000};

        #2 reset_n = 1'b0;
        #1;
        chk("reset_level", lvl_a, 32'h0);
        chk("reset_pwm", {30'h0, pwm_a}, 32'h0);

        // Run saw, then drop reset between edges.
        @(negedge clk_audio);
        reset_n = 1'b1;
        repeat (40) tick();
        chk("saw_running_nonzero", {31'h0, lvl_a[15:0] != 16'h0}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_level", lvl_a, 32'h0);
        chk("async_reset_pwm", {30'h0, pwm_a}, 32'h0);

        // Saw on both channels, both instances.
        mode      = {2'd0, 2'd0};
        phase_inc = {24'h010000, 24'h010000};
        do_reset();
        cnt = 0;
        for (int k = 0; k <= 256; k++) begin
            tick();
            e0 = 16'(k * 256);
            chk("saw_ch0", {16'h0, lvl_a[15:0]}, {16'h0, e0});
            chk("saw_ch1", {16'h0, lvl_a[31:16]}, {16'h0, e0});
            chk("spread_ch0", {16'h0, lvl_s[15:0]}, {16'h0, e0});
            chk("spread_ch1", {16'h0, lvl_s[31:16]}, {16'h0, 16'(32'h8000 + k * 256)});
            if (k >= 1) cnt += int'(pwm_a[0]);
        end
        // sum of one saw period / 65536 = 127.5
        chk("saw_pwm_density", {31'h0, (cnt >= 127 && cnt <= 128)}, 32'h1);

        // Square on ch0, triangle on ch1.
        mode = {2'd2, 2'd1};
        do_reset();
        for (int k = 0; k < 256; k++) begin
            tick();
            e0 = (k < 128) ? 16'hFFFF : 16'h0000;
            e1 = (k < 128) ? 16'(k * 512) : ~16'((k - 128) * 512);
            chk("square_ch0", {16'h0, lvl_a[15:0]}, {16'h0, e0});
            chk("triangle_ch1", {16'h0, lvl_a[31:16]}, {16'h0, e1});
        end

        // Increment change mid-period waits for the wrap.
        mode      = {2'd3, 2'd0};
        phase_inc = {24'h000000, 24'h010000};
        do_reset();
        for (int k = 0; k <= 384; k++) begin
            tick();
            e0 = (k < 256) ? 16'(k * 256) : 16'((k - 256) * 512);
            chk("deferred_inc", {16'h0, lvl_a[15:0]}, {16'h0, e0});
            chk("silent_ch1", {16'h0, lvl_a[31:16]}, 32'h0);
            if (k == 10) phase_inc[23:0] = 24'h020000;
        end

        // Enable drop/resume around level 0x4000.
        phase_inc = {24'h000000, 24'h010000};
        do_reset();
        for (int k = 0; k <= 64; k++) tick();
        chk("pre_disable", {16'h0, lvl_a[15:0]}, 32'h4000);
        enable = 1'b0;
        tick();
        chk("disable_level", {16'h0, lvl_a[15:0]}, 32'h0);
        tick();
        chk("disable_level2", {16'h0, lvl_a[15:0]}, 32'h0);
        chk("disable_pwm", {31'h0, pwm_a[0]}, 32'h0);
        phase_inc[23:0] = 24'h020000;
        repeat (48) tick();
        enable = 1'b1;
        tick();
        chk("resume_0", {16'h0, lvl_a[15:0]}, 32'h4100);
        tick();
        chk("resume_1", {16'h0, lvl_a[15:0]}, 32'h4300);
        tick();
        chk("resume_2", {16'h0, lvl_a[15:0]}, 32'h4500);

        // Full-scale square at inc 0: 65535 ones per 65536 samples.
        mode      = {2'd3, 2'd1};
        phase_inc = 48'h0;
        do_reset();
        tick();
        chk("full_level", {16'h0, lvl_a[15:0]}, 32'hFFFF);
        cnt = 0;
        for (int k = 0; k < 65536; k++) begin
            tick();
            cnt += int'(pwm_a[0]);
        end
        chk("full_pwm_ones", cnt, 32'd65535);

`ifdef AUDIO_TONE_GEN_VOLUME_EN
        mode      = {2'd3, 2'd1};
        phase_inc = {24'h000000, 24'h010000};
        volume    = 8'h01;
        do_reset();
        tick();
        chk("volume_1", {16'h0, lvl_a[15:0]}, 32'h7FFF);
        volume    = 8'h0F;
        do_reset();
        tick();
        chk("volume_15", {16'h0, lvl_a[15:0]}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
